// File: rtl/instr_fetch_buffer.sv
// Instruction fetch buffer: issues word fetches over a req/ack handshake,
// queues {pc, instr} pairs in a small FIFO and presents the head entry to
// decode. A redirect flushes the queue and restarts fetch at a new PC; a
// request already on the bus is completed and its data discarded.
module instr_fetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic                     imem_ack,
  input  logic [31:0]              imem_rdata,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [31:0]              instr,
  output logic [31:0]              instr_pc,
  output logic [31:0]              instr_pc_plus4,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic            r_req;
  logic            w_req_next;
  logic [31:0]     r_addr;
  logic [31:0]     w_addr_next;
  logic [31:0]     r_fetch_pc;
  logic [31:0]     w_fetch_pc_next;
  logic [31:0]     w_pc_inc;

  logic [31:0]     r_mem_pc    [DEPTH];
  logic [31:0]     r_mem_instr [DEPTH];
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   w_rd_ptr_next;
  logic [PW-1:0]   w_wr_ptr_next;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   w_count_next;
  logic [CW-1:0]   w_count_after_pop;
  logic [CW-1:0]   w_count_after_push;

  logic            w_hs;
  logic            w_pop;
  logic            w_push;
  logic            r_valid;
  logic [31:0]     r_instr;
  logic [31:0]     r_instr_pc;
  logic [31:0]     r_instr_pc_plus4;
  logic [31:0]     w_head_pc;
  logic [31:0]     w_head_instr;

  // A handshake only counts while we are actually requesting; a pop needs a valid head and no flush.
  assign w_hs               = r_req & imem_ack;
  assign w_pop              = r_valid & instr_ready & ~redirect;
  assign w_pc_inc           = r_fetch_pc + 32'd4;
  assign w_count_after_pop  = r_count - CW'(w_pop);
  assign w_count_after_push = w_count_after_pop + CW'(1'b1);

  // Fetch FSM: next state, request/address and fetch PC (room check includes the word being accepted).
  always_comb begin
    w_state_next    = r_state;
    w_req_next      = r_req;
    w_addr_next     = r_addr;
    w_fetch_pc_next = r_fetch_pc;
    w_push          = 1'b0;
    if (redirect) begin
      w_fetch_pc_next = {redirect_pc[31:2], 2'b00};
    end else begin
      w_fetch_pc_next = r_fetch_pc;
    end
    case (r_state)
      ST_IDLE: begin
        if (!redirect && (w_count_after_pop < DEPTH_C)) begin
          w_state_next = ST_WAIT;
          w_req_next   = 1'b1;
          w_addr_next  = r_fetch_pc;
        end else begin
          w_req_next   = 1'b0;
        end
      end
      ST_WAIT: begin
        if (redirect) begin
          if (w_hs) begin
            w_state_next = ST_IDLE;
            w_req_next   = 1'b0;
          end else begin
            w_state_next = ST_DROP;
            w_req_next   = 1'b1;
          end
        end else if (w_hs) begin
          w_push          = 1'b1;
          w_fetch_pc_next = w_pc_inc;
          if (w_count_after_push < DEPTH_C) begin
            w_addr_next  = w_pc_inc;
          end else begin
            w_state_next = ST_IDLE;
            w_req_next   = 1'b0;
          end
        end else begin
          w_req_next = 1'b1;
        end
      end
      ST_DROP: begin
        if (w_hs) begin
          w_state_next = ST_IDLE;
          w_req_next   = 1'b0;
        end else begin
          w_req_next   = 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_req_next   = 1'b0;
      end
    endcase
  end

  // FIFO pointer/count update and selection of the head entry that will be visible after this edge.
  always_comb begin
    if (redirect) begin
      w_rd_ptr_next = '0;
      w_wr_ptr_next = '0;
      w_count_next  = '0;
    end else begin
      w_rd_ptr_next = r_rd_ptr + PW'(w_pop);
      w_wr_ptr_next = r_wr_ptr + PW'(w_push);
      w_count_next  = w_count_after_pop + CW'(w_push);
    end
    if (w_push && (r_wr_ptr == w_rd_ptr_next)) begin
      w_head_pc    = r_fetch_pc;
      w_head_instr = imem_rdata;
    end else begin
      w_head_pc    = r_mem_pc[w_rd_ptr_next];
      w_head_instr = r_mem_instr[w_rd_ptr_next];
    end
  end

  // State, fetch control, FIFO bookkeeping and registered head outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state          <= ST_IDLE;
      r_req            <= 1'b0;
      r_addr           <= RESET_PC;
      r_fetch_pc       <= RESET_PC;
      r_rd_ptr         <= '0;
      r_wr_ptr         <= '0;
      r_count          <= '0;
      r_valid          <= 1'b0;
      r_instr          <= 32'h0000_0000;
      r_instr_pc       <= 32'h0000_0000;
      r_instr_pc_plus4 <= 32'h0000_0000;
    end else begin
      r_state    <= w_state_next;
      r_req      <= w_req_next;
      r_addr     <= w_addr_next;
      r_fetch_pc <= w_fetch_pc_next;
      r_rd_ptr   <= w_rd_ptr_next;
      r_wr_ptr   <= w_wr_ptr_next;
      r_count    <= w_count_next;
      r_valid    <= (w_count_next != '0);
      if (!redirect) begin
        r_instr          <= w_head_instr;
        r_instr_pc       <= w_head_pc;
        r_instr_pc_plus4 <= w_head_pc + 32'd4;
      end
    end
  end

  // FIFO storage; contents are only meaningful where the count says so, so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_pc[r_wr_ptr]    <= r_fetch_pc;
      r_mem_instr[r_wr_ptr] <= imem_rdata;
    end
  end

  assign imem_req       = r_req;
  assign imem_addr      = r_addr;
  assign instr_valid    = r_valid;
  assign instr          = r_instr;
  assign instr_pc       = r_instr_pc;
  assign instr_pc_plus4 = r_instr_pc_plus4;
  assign fifo_count     = r_count;

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Bench for instr_fetch_buffer: directed scenarios with literal expectations,
// a randomized phase, and a queue-based reference model compared every cycle.
`timescale 1ns/1ps
module tb_instr_fetch_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_plus4;
  logic [2:0]  fifo_count;

  logic        rst2;
  logic        req2;
  logic [31:0] addr2;
  logic        valid2;
  logic [31:0] instr2;
  logic [31:0] pc2;
  logic [31:0] pc42;
  logic [2:0]  cnt2;

  int passes = 0;
  int checks = 0;

  // memory behaviour knobs
  int          lat_fix = 0;
  bit          lat_rand = 1'b0;
  logic [31:0] data_key = 32'h0;
  bit          stray_en = 1'b0;
  bit          stray_force = 1'b0;

  // reference model state
  logic [31:0] q_pc[$];
  logic [31:0] q_ins[$];
  bit          m_req;
  bit          m_drop;
  logic [31:0] m_addr;
  logic [31:0] m_fetch;

  always #5 clk = ~clk;

  instr_fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc), .instr_pc_plus4(instr_pc_plus4),
    .fifo_count(fifo_count)
  );

  // wrap-around instance: single-cycle ack memory returning the address, consumer always ready
  instr_fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .rst(rst2), .imem_req(req2), .imem_addr(addr2),
    .imem_ack(req2), .imem_rdata(addr2), .redirect(1'b0),
    .redirect_pc(32'h0000_0000), .instr_valid(valid2), .instr_ready(1'b1),
    .instr(instr2), .instr_pc(pc2), .instr_pc_plus4(pc42),
    .fifo_count(cnt2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  // Reference model: outstanding request tracked as (req, addr, discard) plus a queue of fetched pairs.
  initial begin
    bit hs;
    bit pop;
    m_req = 1'b0; m_drop = 1'b0; m_addr = 32'h0; m_fetch = 32'h0;
    forever begin
      @(posedge clk);
      if (rst) begin
        q_pc.delete(); q_ins.delete();
        m_req = 1'b0; m_drop = 1'b0; m_addr = 32'h0; m_fetch = 32'h0;
      end else begin
        hs  = m_req && imem_ack;
        pop = (q_pc.size() != 0) && instr_ready && !redirect;
        if (redirect) begin
          q_pc.delete(); q_ins.delete();
          m_fetch = {redirect_pc[31:2], 2'b00};
          if (m_req && !hs) m_drop = 1'b1;
          else begin m_req = 1'b0; m_drop = 1'b0; end
        end else begin
          if (pop) begin void'(q_pc.pop_front()); void'(q_ins.pop_front()); end
          if (hs) begin
            if (m_drop) begin
              m_drop = 1'b0; m_req = 1'b0;
            end else begin
              q_pc.push_back(m_addr); q_ins.push_back(imem_rdata);
              m_fetch = m_fetch + 32'd4;
              if (q_pc.size() < DEPTH) m_addr = m_fetch;
              else m_req = 1'b0;
            end
          end else if (!m_req && q_pc.size() < DEPTH) begin
            m_req = 1'b1; m_addr = m_fetch;
          end
        end
      end
    end
  end

  // Instruction memory: per-request latency, data = addr ^ key, optional stray acks when idle.
  initial begin
    bit last_req;
    bit last_ack;
    int wait_cnt;
    int cur_lat;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    last_req = 1'b0; last_ack = 1'b0; wait_cnt = 0; cur_lat = 0;
    forever begin
      @(posedge clk);
      #2;
      if (!last_req || last_ack) begin
        wait_cnt = 0;
        cur_lat = lat_rand ? int'($urandom_range(0, 3)) : lat_fix;
      end else begin
        wait_cnt++;
      end
      if (imem_req) begin
        imem_ack   = (wait_cnt >= cur_lat);
        imem_rdata = imem_ack ? (imem_addr ^ data_key) : $urandom;
      end else begin
        imem_ack   = stray_force || (stray_en && ($urandom_range(0, 7) == 0));
        imem_rdata = $urandom;
      end
      last_req = imem_req;
      last_ack = imem_ack;
    end
  end

  task automatic compare();
    if (rst) begin
      chk("rst_req", 32'(imem_req), 32'h0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_valid", 32'(instr_valid), 32'h0);
      chk("rst_count", 32'(fifo_count), 32'h0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_pc", instr_pc, 32'h0);
      chk("rst_pc4", instr_pc_plus4, 32'h0);
    end else begin
      chk("req", 32'(imem_req), 32'(m_req));
      if (m_req) chk("addr", imem_addr, m_addr);
      chk("count", 32'(fifo_count), 32'(q_pc.size()));
      chk("valid", 32'(instr_valid), 32'(q_pc.size() != 0));
      if (q_pc.size() != 0) begin
        chk("head_pc", instr_pc, q_pc[0]);
        chk("head_instr", instr, q_ins[0]);
        chk("head_pc4", instr_pc_plus4, q_pc[0] + 32'd4);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  // Hard time limit so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp5_pc  [3];
    logic [31:0] exp5_pc4 [3];
    int idx;
    bit found;
    int bias;
    rst = 1'b1; rst2 = 1'b1;
    redirect = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b1;
    exp5_pc  = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    exp5_pc4 = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};

    fork
      forever begin
        @(negedge clk);
        compare();
      end
    join_none

    // wrap-around of the fetch PC from a high reset PC
    repeat (2) tick();
    rst2 = 1'b0;
    idx = 0;
    for (int c = 0; c < 12 && idx < 3; c++) begin
      tick();
      if (valid2) begin
        chk("wrap_pc", pc2, exp5_pc[idx]);
        chk("wrap_pc4", pc42, exp5_pc4[idx]);
        idx++;
      end
    end
    chk("wrap_seen3", 32'(idx), 32'd3);

    // streaming with single-cycle ack, data = addr
    lat_fix = 0; lat_rand = 1'b0; data_key = 32'h0; stray_en = 1'b0; instr_ready = 1'b1;
    do_reset();
    tick();
    chk("t1_req", 32'(imem_req), 32'h1);
    chk("t1_addr", imem_addr, 32'h0);
    tick();
    chk("t1_valid", 32'(instr_valid), 32'h1);
    chk("t1_pc0", instr_pc, 32'h0);
    chk("t1_pc4_0", instr_pc_plus4, 32'h4);
    tick();
    chk("t1_pc1", instr_pc, 32'h4);
    tick();
    chk("t1_pc2", instr_pc, 32'h8);
    chk("t1_instr2", instr, 32'h8);

    // stalled consumer fills the FIFO, then drains and fetch resumes
    instr_ready = 1'b0;
    do_reset();
    repeat (6) tick();
    chk("t2_count", 32'(fifo_count), 32'd4);
    chk("t2_req", 32'(imem_req), 32'h0);
    chk("t2_pc", instr_pc, 32'h0);
    instr_ready = 1'b1;
    tick();
    chk("t2_resume_req", 32'(imem_req), 32'h1);
    chk("t2_resume_addr", imem_addr, 32'd16);
    chk("t2_head", instr_pc, 32'h4);
    chk("t2_count3", 32'(fifo_count), 32'd3);

    // redirect while a slow fetch is outstanding
    lat_fix = 3;
    do_reset();
    tick(); tick();
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    tick();
    redirect = 1'b0;
    chk("t3_hold_req", 32'(imem_req), 32'h1);
    chk("t3_hold_addr", imem_addr, 32'h0);
    chk("t3_empty", 32'(fifo_count), 32'h0);
    tick(); tick();
    chk("t3_drop_done", 32'(imem_req), 32'h0);
    tick();
    chk("t3_new_req", 32'(imem_req), 32'h1);
    chk("t3_new_addr", imem_addr, 32'h0000_0100);
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      tick();
      if (instr_valid) found = 1'b1;
    end
    chk("t3_valid_seen", 32'(found), 32'h1);
    chk("t3_first_pc", instr_pc, 32'h0000_0100);

    // redirect with a simultaneous pop on a partly full FIFO
    lat_fix = 0; instr_ready = 1'b0;
    do_reset();
    repeat (4) tick();
    chk("t4_count3", 32'(fifo_count), 32'd3);
    redirect = 1'b1; redirect_pc = 32'h0000_0040; instr_ready = 1'b1;
    tick();
    redirect = 1'b0;
    chk("t4_count0", 32'(fifo_count), 32'h0);
    chk("t4_valid0", 32'(instr_valid), 32'h0);
    tick();
    chk("t4_req", 32'(imem_req), 32'h1);
    chk("t4_addr", imem_addr, 32'h0000_0040);

    // randomized traffic against the model
    lat_rand = 1'b1; data_key = $urandom; stray_en = 1'b1;
    bias = 4;
    for (int c = 0; c < 3000; c++) begin
      if (c % 100 == 0) bias = int'($urandom_range(0, 4));
      instr_ready = (int'($urandom_range(0, 3)) < bias);
      redirect    = ($urandom_range(0, 15) == 0);
      redirect_pc = $urandom;
      rst         = ($urandom_range(0, 399) == 0);
      tick();
    end
    rst = 1'b0; redirect = 1'b0;

    // reset in the middle of an outstanding fetch, with a stray ack during reset
    lat_rand = 1'b0; lat_fix = 2; stray_en = 1'b0; instr_ready = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      tick();
      if (imem_req && !imem_ack) found = 1'b1;
    end
    chk("t6_in_wait", 32'(found), 32'h1);
    rst = 1'b1; stray_force = 1'b1;
    #1;
    chk("t6_req", 32'(imem_req), 32'h0);
    chk("t6_addr", imem_addr, 32'h0);
    chk("t6_valid", 32'(instr_valid), 32'h0);
    chk("t6_count", 32'(fifo_count), 32'h0);
    chk("t6_pc", instr_pc, 32'h0);
    tick(); tick();
    rst = 1'b0; stray_force = 1'b0;
    tick();
    chk("t6_restart_req", 32'(imem_req), 32'h1);
    chk("t6_restart_addr", imem_addr, 32'h0);
    chk("t6_count_after", 32'(fifo_count), 32'h0);
    repeat (20) tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
